// File: rtl/rv32i_id_ex_stage.sv
// ID/EX pipeline register with the EX-stage operand-forwarding network and load-use detection.
// Define RV32I_FORWARDING_EN to enable EX/MEM and MEM/WB bypass; otherwise RAW hazards stall.
module rv32i_id_ex_stage #(
    parameter int XLEN   = 32,
    parameter int RA_W   = 5,
    parameter int ALUC_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [RA_W-1:0]   id_rs1,
    input  logic [RA_W-1:0]   id_rs2,
    input  logic [RA_W-1:0]   id_rd,
    input  logic [ALUC_W-1:0] id_alu_ctrl,
    input  logic              id_src_imm,
    input  logic              id_src_pc,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic [RA_W-1:0]   mem_rd,
    input  logic              mem_reg_write,
    input  logic [XLEN-1:0]   mem_result,
    input  logic [RA_W-1:0]   wb_rd,
    input  logic              wb_reg_write,
    input  logic [XLEN-1:0]   wb_result,
    output logic              ex_valid,
    output logic [XLEN-1:0]   ex_alu_a,
    output logic [XLEN-1:0]   ex_alu_b,
    output logic [ALUC_W-1:0] ex_alu_ctrl,
    output logic [XLEN-1:0]   ex_store_data,
    output logic [XLEN-1:0]   ex_pc,
    output logic [RA_W-1:0]   ex_rd,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              hazard_stall
);

    logic              valid_q;
    logic [XLEN-1:0]   pc_q;
    logic [XLEN-1:0]   rs1_data_q;
    logic [XLEN-1:0]   rs2_data_q;
    logic [XLEN-1:0]   imm_q;
    logic [RA_W-1:0]   rs1_q;
    logic [RA_W-1:0]   rs2_q;
    logic [RA_W-1:0]   rd_q;
    logic [ALUC_W-1:0] alu_ctrl_q;
    logic              src_imm_q;
    logic              src_pc_q;
    logic              reg_write_q;
    logic              mem_read_q;
    logic              mem_write_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q     <= 1'b0;
            pc_q        <= '0;
            rs1_data_q  <= '0;
            rs2_data_q  <= '0;
            imm_q       <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            alu_ctrl_q  <= '0;
            src_imm_q   <= 1'b0;
            src_pc_q    <= 1'b0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
        end else if (flush) begin
            // Bubble: only the qualifying bits matter, data fields simply hold.
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
        end else if (!stall) begin
            valid_q     <= id_valid;
            pc_q        <= id_pc;
            rs1_data_q  <= id_rs1_data;
            rs2_data_q  <= id_rs2_data;
            imm_q       <= id_imm;
            rs1_q       <= id_rs1;
            rs2_q       <= id_rs2;
            rd_q        <= id_rd;
            alu_ctrl_q  <= id_alu_ctrl;
            src_imm_q   <= id_src_imm;
            src_pc_q    <= id_src_pc;
            reg_write_q <= id_reg_write & id_valid;
            mem_read_q  <= id_mem_read & id_valid;
            mem_write_q <= id_mem_write & id_valid;
        end
    end

    logic [XLEN-1:0] fwd_rs1;
    logic [XLEN-1:0] fwd_rs2;
    logic            load_use;

    assign load_use = ex_valid & ex_mem_read & (ex_rd != '0) & id_valid
                    & ((ex_rd == id_rs1) | (ex_rd == id_rs2));

`ifdef RV32I_FORWARDING_EN
    // EX/MEM is the younger producer, so it takes precedence over MEM/WB.
    always_comb begin
        fwd_rs1 = rs1_data_q;
        if (mem_reg_write && (mem_rd != '0) && (mem_rd == rs1_q))
            fwd_rs1 = mem_result;
        else if (wb_reg_write && (wb_rd != '0) && (wb_rd == rs1_q))
            fwd_rs1 = wb_result;
    end

    always_comb begin
        fwd_rs2 = rs2_data_q;
        if (mem_reg_write && (mem_rd != '0) && (mem_rd == rs2_q))
            fwd_rs2 = mem_result;
        else if (wb_reg_write && (wb_rd != '0) && (wb_rd == rs2_q))
            fwd_rs2 = wb_result;
    end

    assign hazard_stall = load_use;
`else
    logic raw_rs1;
    logic raw_rs2;
    logic unused_fwd;

    assign fwd_rs1 = rs1_data_q;
    assign fwd_rs2 = rs2_data_q;

    // MEM/WB producers are covered by the regfile's write-before-read.
    assign raw_rs1 = (id_rs1 != '0) & ((ex_reg_write & (ex_rd == id_rs1))
                                     | (mem_reg_write & (mem_rd == id_rs1)));
    assign raw_rs2 = (id_rs2 != '0) & ((ex_reg_write & (ex_rd == id_rs2))
                                     | (mem_reg_write & (mem_rd == id_rs2)));
    assign hazard_stall = load_use | (id_valid & (raw_rs1 | raw_rs2));

    assign unused_fwd = ^{mem_result, wb_rd, wb_reg_write, wb_result, rs1_q, rs2_q};
`endif

    assign ex_valid      = valid_q;
    assign ex_pc         = pc_q;
    assign ex_rd         = rd_q;
    assign ex_alu_ctrl   = alu_ctrl_q;
    assign ex_reg_write  = reg_write_q & valid_q;
    assign ex_mem_read   = mem_read_q & valid_q;
    assign ex_mem_write  = mem_write_q & valid_q;
    assign ex_alu_a      = src_pc_q ? pc_q : fwd_rs1;
    assign ex_alu_b      = src_imm_q ? imm_q : fwd_rs2;
    assign ex_store_data = fwd_rs2;

endmodule

// File: tb/tb_rv32i_id_ex_stage.sv
// Self-checking bench for rv32i_id_ex_stage: directed vector table plus stall/flush/reset sequences.
// Expectations cover both builds, selected by RV32I_FORWARDING_EN.
module tb_rv32i_id_ex_stage;

    localparam logic T = 1'b1;
    localparam logic F = 1'b0;

    logic        clk = 1'b0;
    logic        rst, stall, flush, id_valid;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [3:0]  id_alu_ctrl;
    logic        id_src_imm, id_src_pc, id_reg_write, id_mem_read, id_mem_write;
    logic [4:0]  mem_rd, wb_rd;
    logic        mem_reg_write, wb_reg_write;
    logic [31:0] mem_result, wb_result;
    logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, hazard_stall;
    logic [31:0] ex_alu_a, ex_alu_b, ex_store_data, ex_pc;
    logic [3:0]  ex_alu_ctrl;
    logic [4:0]  ex_rd;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rv32i_id_ex_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
        .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_alu_ctrl(id_alu_ctrl),
        .id_src_imm(id_src_imm), .id_src_pc(id_src_pc), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_result(mem_result),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_result(wb_result),
        .ex_valid(ex_valid), .ex_alu_a(ex_alu_a), .ex_alu_b(ex_alu_b), .ex_alu_ctrl(ex_alu_ctrl),
        .ex_store_data(ex_store_data), .ex_pc(ex_pc), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .hazard_stall(hazard_stall)
    );

    typedef struct {
        logic        v;
        logic [31:0] pc, rs1d, rs2d, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [3:0]  ctrl;
        logic        simm, spc, rw, mr, mw;
        logic [4:0]  mrd;
        logic        mrw;
        logic [31:0] mres;
        logic [4:0]  wrd;
        logic        wrw;
        logic [31:0] wres;
        logic        ev, erw, emr, emw;
        logic [31:0] a_f, b_f, sd_f;
        logic        hz_f;
        logic [31:0] a_n, b_n, sd_n;
        logic        hz_n;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive_vec(input vec_t t);
        id_valid = t.v; id_pc = t.pc; id_rs1_data = t.rs1d; id_rs2_data = t.rs2d; id_imm = t.imm;
        id_rs1 = t.rs1; id_rs2 = t.rs2; id_rd = t.rd; id_alu_ctrl = t.ctrl;
        id_src_imm = t.simm; id_src_pc = t.spc;
        id_reg_write = t.rw; id_mem_read = t.mr; id_mem_write = t.mw;
        mem_rd = t.mrd; mem_reg_write = t.mrw; mem_result = t.mres;
        wb_rd = t.wrd; wb_reg_write = t.wrw; wb_result = t.wres;
    endtask

    initial begin
        logic [31:0] exp_a;
        vec_t        seq;

        vecs[0] = '{T, 32'h40, 32'd5, 32'd7, 32'd0, 5'd1, 5'd2, 5'd3, 4'd0, F, F, T, F, F,
                    5'd1, T, 32'd100, 5'd1, T, 32'd200, T, T, F, F,
                    32'd100, 32'd7, 32'd7, F, 32'd5, 32'd7, 32'd7, T};
        vecs[1] = '{T, 32'h44, 32'd5, 32'd7, 32'd0, 5'd1, 5'd2, 5'd4, 4'd0, F, F, T, F, F,
                    5'd9, T, 32'd100, 5'd2, T, 32'd200, T, T, F, F,
                    32'd5, 32'd200, 32'd200, F, 32'd5, 32'd7, 32'd7, F};
        vecs[2] = '{T, 32'h48, 32'd0, 32'h11, 32'd0, 5'd0, 5'd6, 5'd7, 4'd2, F, F, T, F, F,
                    5'd0, T, 32'hDEAD, 5'd0, T, 32'hBEEF, T, T, F, F,
                    32'd0, 32'h11, 32'h11, F, 32'd0, 32'h11, 32'h11, F};
        vecs[3] = '{T, 32'h4C, 32'h55, 32'h66, 32'hFFFF_FFF0, 5'd8, 5'd9, 5'd10, 4'd0, T, F, F, F, T,
                    5'd8, F, 32'd1, 5'd8, F, 32'd2, T, F, F, T,
                    32'h55, 32'hFFFF_FFF0, 32'h66, F, 32'h55, 32'hFFFF_FFF0, 32'h66, F};
        vecs[4] = '{T, 32'h100, 32'd0, 32'd0, 32'h2000, 5'd0, 5'd0, 5'd11, 4'd0, T, T, T, F, F,
                    5'd0, F, 32'd0, 5'd0, F, 32'd0, T, T, F, F,
                    32'h100, 32'h2000, 32'd0, F, 32'h100, 32'h2000, 32'd0, F};
        vecs[5] = '{F, 32'h104, 32'h12, 32'h13, 32'd0, 5'd12, 5'd13, 5'd12, 4'd3, F, F, T, T, T,
                    5'd0, F, 32'd0, 5'd0, F, 32'd0, F, F, F, F,
                    32'h12, 32'h13, 32'h13, F, 32'h12, 32'h13, 32'h13, F};
        vecs[6] = '{T, 32'h108, 32'h1000, 32'd0, 32'd4, 5'd1, 5'd0, 5'd5, 4'd0, T, F, T, T, F,
                    5'd1, T, 32'h2000, 5'd0, F, 32'd0, T, T, T, F,
                    32'h2000, 32'd4, 32'd0, F, 32'h1000, 32'd4, 32'd0, T};

        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        drive_vec(vecs[4]);
        id_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_valid", {31'd0, ex_valid}, 32'd0);
        check("reset_ctrl", {28'd0, ex_alu_ctrl}, 32'd0);
        check("reset_alu_a", ex_alu_a, 32'd0);
        check("reset_hazard", {31'd0, hazard_stall}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            drive_vec(vecs[i]);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_valid", i), {31'd0, ex_valid}, {31'd0, vecs[i].ev});
            check($sformatf("v%0d_reg_write", i), {31'd0, ex_reg_write}, {31'd0, vecs[i].erw});
            check($sformatf("v%0d_mem_read", i), {31'd0, ex_mem_read}, {31'd0, vecs[i].emr});
            check($sformatf("v%0d_mem_write", i), {31'd0, ex_mem_write}, {31'd0, vecs[i].emw});
            check($sformatf("v%0d_ctrl", i), {28'd0, ex_alu_ctrl}, {28'd0, vecs[i].ctrl});
            check($sformatf("v%0d_rd", i), {27'd0, ex_rd}, {27'd0, vecs[i].rd});
            check($sformatf("v%0d_pc", i), ex_pc, vecs[i].pc);
`ifdef RV32I_FORWARDING_EN
            check($sformatf("v%0d_alu_a", i), ex_alu_a, vecs[i].a_f);
            check($sformatf("v%0d_alu_b", i), ex_alu_b, vecs[i].b_f);
            check($sformatf("v%0d_store", i), ex_store_data, vecs[i].sd_f);
            check($sformatf("v%0d_hazard", i), {31'd0, hazard_stall}, {31'd0, vecs[i].hz_f});
`else
            check($sformatf("v%0d_alu_a", i), ex_alu_a, vecs[i].a_n);
            check($sformatf("v%0d_alu_b", i), ex_alu_b, vecs[i].b_n);
            check($sformatf("v%0d_store", i), ex_store_data, vecs[i].sd_n);
            check($sformatf("v%0d_hazard", i), {31'd0, hazard_stall}, {31'd0, vecs[i].hz_n});
`endif
        end

        // Load-use: LW x5 in EX, dependent instruction in ID.
        @(negedge clk);
        seq = vecs[6];
        seq.rs1 = 5'd2; seq.mrd = 5'd0; seq.mrw = F;
        drive_vec(seq);
        @(posedge clk);
        #1;
        id_rs1 = 5'd7; id_rs2 = 5'd5; id_valid = 1'b1;
        #1;
        check("loaduse_rs2", {31'd0, hazard_stall}, 32'd1);
        id_valid = 1'b0;
        #1;
        check("loaduse_idle", {31'd0, hazard_stall}, 32'd0);
        id_rs1 = 5'd5; id_rs2 = 5'd0; id_valid = 1'b1;
        #1;
        check("loaduse_rs1", {31'd0, hazard_stall}, 32'd1);

        // Stall and flush on the same edge: the bubble wins.
        @(negedge clk);
        drive_vec(vecs[1]);
        @(negedge clk);
        stall = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1;
        check("flush_over_stall_valid", {31'd0, ex_valid}, 32'd0);
        check("flush_over_stall_rw", {31'd0, ex_reg_write}, 32'd0);

        // Stall alone holds every EX field for three edges.
        @(negedge clk);
        stall = 1'b0; flush = 1'b0;
        seq = vecs[1];
        seq.pc = 32'h200; seq.rs1d = 32'hA; seq.rs2d = 32'hB; seq.rs1 = 5'd14; seq.rs2 = 5'd15;
        seq.rd = 5'd16; seq.ctrl = 4'd5; seq.mrd = 5'd0; seq.mrw = F; seq.wrd = 5'd0; seq.wrw = F;
        drive_vec(seq);
        @(negedge clk);
        stall = 1'b1;
        id_pc = 32'h300; id_rs1_data = 32'h99; id_rs2_data = 32'h98; id_rd = 5'd20;
        id_alu_ctrl = 4'd1; id_valid = 1'b0; id_rs1 = 5'd0; id_rs2 = 5'd0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("stall%0d_valid", c), {31'd0, ex_valid}, 32'd1);
            check($sformatf("stall%0d_rw", c), {31'd0, ex_reg_write}, 32'd1);
            check($sformatf("stall%0d_pc", c), ex_pc, 32'h200);
            check($sformatf("stall%0d_rd", c), {27'd0, ex_rd}, 32'd16);
            check($sformatf("stall%0d_ctrl", c), {28'd0, ex_alu_ctrl}, 32'd5);
            check($sformatf("stall%0d_alu_a", c), ex_alu_a, 32'hA);
            check($sformatf("stall%0d_alu_b", c), ex_alu_b, 32'hB);
        end
        // A producer appearing while held is picked up only by the bypass build.
        mem_rd = 5'd14; mem_reg_write = 1'b1; mem_result = 32'h77;
        #1;
`ifdef RV32I_FORWARDING_EN
        exp_a = 32'h77;
`else
        exp_a = 32'hA;
`endif
        check("stall_live_fwd", ex_alu_a, exp_a);

        // Asynchronous reset mid-cycle with valid EX contents.
        @(negedge clk);
        stall = 1'b0;
        mem_rd = 5'd0; mem_reg_write = 1'b0;
        drive_vec(vecs[4]);
        @(posedge clk);
        #1;
        check("pre_reset_valid", {31'd0, ex_valid}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_valid", {31'd0, ex_valid}, 32'd0);
        check("async_reset_alu_a", ex_alu_a, 32'd0);
        check("async_reset_alu_b", ex_alu_b, 32'd0);
        check("async_reset_ctrl", {28'd0, ex_alu_ctrl}, 32'd0);
        check("async_reset_rw", {31'd0, ex_reg_write}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
